mux_arbiter2: RTL and testbench
===============================

# mux_arbiter2

Two-requester round-robin arbiter that owns the select line of the 2:1 mux feeding a shared datapath resource. Each requester holds a request for as long as it needs the resource. The block grants ownership with a registered one-hot grant and drives the mux select to match. A hold limit prevents one requester from starving the other.

## Interface
- MAX_HOLD, 8: maximum cycles an owner keeps the grant while the other side is waiting. 0 disables preemption. Legal range is 0..255.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  2  request per requester. req[k]=1 means requester k wants, or keeps, ownership.
- gnt  out  2  registered grant. One-hot or zero, never 2'b11.
- sel  out  1  registered mux select. 0 routes in0 (requester 0); 1 routes in1 (requester 1).
- busy  out  1  high whenever gnt != 0
- preempt  out  1  one-cycle pulse on the first cycle of a grant produced by hold-limit preemption

## Operation
- States: IDLE, OWN0, OWN1.
  - gnt is 00 in IDLE, 01 in OWN0 and 10 in OWN1.
  - sel equals the owner index in OWNk.
  - In IDLE, sel holds its last value.
- Priority pointer `last`:
  - `last` is the index of the most recent owner. It is updated on every exit from OWNk.
  - Reset value is 1, so requester 0 wins the first tie.
- From IDLE:
  - If exactly one req bit is set, go to OWN of that requester.
  - If both are set, go to OWN(~last).
  - If none are set, stay in IDLE.
- From OWNk with req[k]=1:
  - Stay in OWNk unless the preemption condition holds. In that case, go to OWN(1-k) and pulse preempt.
- From OWNk with req[k]=0:
  - If req[1-k]=1, go to OWN(1-k) directly, with no idle cycle between grants.
  - Otherwise, go to IDLE.
- Hold counter `hcnt`:
  - Width is enough to hold MAX_HOLD.
  - Cleared to 0 on every state change.
  - In OWNk, increments on each edge where req[1-k]=1, saturating at MAX_HOLD.
  - Cleared on any edge where req[1-k]=0, so waiting must be continuous.
- Preemption condition:
  - MAX_HOLD != 0, the state is OWNk, req[k]=1, req[1-k]=1 and hcnt == MAX_HOLD-1.
  - The preempted requester keeps no priority. If it keeps requesting, it is the waiting side in the new state.
- Preemption with MAX_HOLD=0:
  - The owner keeps the grant until it drops req, however long the other side waits.

## Timing
- Reset (reset_n low, asynchronous, immediate):
  - State IDLE, gnt=00, sel=0, busy=0, preempt=0, hcnt=0, last=1.
  - On release, the first active edge samples req normally.
- Grant latency:
  - req sampled high at edge N (IDLE) gives gnt and sel updated after edge N, i.e. one cycle.
  - Combinational req-to-gnt paths are forbidden.
- Release:
  - req[k] sampled low at edge M makes gnt[k] fall after edge M.
  - If the other side is waiting, gnt[1-k] rises on the same edge.
- Preemption timing:
  - With the other side waiting continuously from the first owned cycle, the owner holds for exactly MAX_HOLD cycles.
  - The switch happens on the MAX_HOLD-th edge.
  - preempt is high for exactly the first cycle of the new grant.
- Simultaneous events:
  - If the owner drops req on the same edge the preemption condition would fire, treat it as a normal release: preempt stays 0.
  - If both req bits rise together in IDLE, `last` decides.
- Reset asserted mid-grant:
  - gnt clears immediately, with no waiting for a clock.
  - The pointer returns to 1.
- sel and gnt always change on the same edge and are never inconsistent.

## Test plan
- Reset:
  - Stimulus: assert reset_n=0 while in OWN1, with req=11.
  - Required response: gnt=00, sel=0, busy=0 and preempt=0 immediately. After release with req=11, first grant is gnt=01.
- Single requester:
  - Stimulus: req=10 for 3 cycles, then 00.
  - Required response: gnt=10 and sel=1 one cycle after req rises, held for 3 cycles. gnt=00 one cycle after req falls. sel stays 1 in IDLE.
- Tie and handoff:
  - Stimulus: req=11 from IDLE; requester 0 drops after 2 cycles.
  - Required response: gnt=01, then gnt=10 on the very next edge with no 00 cycle between. preempt=0 throughout.
- Fairness:
  - Stimulus: repeated 1-cycle gaps with req=11 each time.
  - Required response: grants alternate 01, 10, 01, 10.
- Preemption with MAX_HOLD=4:
  - Stimulus: req=11 held continuously.
  - Required response: gnt=01 for exactly 4 cycles, then 10 with preempt=1 for one cycle, then 01 again after 4 more cycles.
- Preemption disabled or interrupted:
  - Stimulus: MAX_HOLD=0 with req=11 for 50 cycles.
    - Required response: gnt stays 01 and preempt never asserts.
  - Stimulus: MAX_HOLD=4 with req[1] dropping for one cycle mid-wait.
    - Required response: hcnt restarts, so preemption is delayed by the full count.

Source files
------------

// File: rtl/mux_arbiter2.sv
// rtl/mux_arbiter2.sv - two-requester round-robin arbiter driving a 2:1 mux select
module mux_arbiter2 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy,
  output logic       preempt
);

  localparam int              HW        = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HCNT_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0]   HCNT_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic            HOLD_EN   = (MAX_HOLD != 0);

  // State encoding equals the grant vector, so gnt comes straight off flops.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic          last;
  logic          sel_q;
  logic          preempt_q, preempt_nxt;
  logic          owner;
  logic          own_req;
  logic          other_req;

  assign owner     = (state == OWN1);
  assign own_req   = req[owner];
  assign other_req = req[~owner];

  // Next-state, preemption decision and hold-counter update.
  always_comb begin
    state_nxt   = state;
    preempt_nxt = 1'b0;
    hcnt_nxt    = '0;
    case (state)
      IDLE: begin
        case (req)
          2'b01:   state_nxt = OWN0;
          2'b10:   state_nxt = OWN1;
          2'b11:   state_nxt = last ? OWN0 : OWN1;
          default: state_nxt = IDLE;
        endcase
      end
      OWN0, OWN1: begin
        if (own_req) begin
          // Owner still wants the resource: only the hold limit can take it away.
          if (HOLD_EN && other_req && (hcnt == HCNT_LAST)) begin
            state_nxt   = owner ? OWN0 : OWN1;
            preempt_nxt = 1'b1;
          end
        end else if (other_req) begin
          state_nxt = owner ? OWN0 : OWN1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Counter only runs while the same owner stays and the other side waits without a break.
    if ((state != IDLE) && (state_nxt == state) && other_req) begin
      hcnt_nxt = (hcnt == HCNT_MAX) ? hcnt : hcnt + 1'b1;
    end
  end

  // State, counter, priority pointer, mux select and preempt pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hcnt      <= '0;
      last      <= 1'b1;
      sel_q     <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      preempt_q <= preempt_nxt;
      if ((state != IDLE) && (state_nxt != state)) begin
        last <= owner;
      end
      if (state_nxt == OWN0) begin
        sel_q <= 1'b0;
      end else if (state_nxt == OWN1) begin
        sel_q <= 1'b1;
      end
    end
  end

  // Outputs are pure register decodes; no combinational path from req.
  always_comb begin
    gnt     = state;
    busy    = (state != IDLE);
    sel     = sel_q;
    preempt = preempt_q;
  end

endmodule

// File: tb/tb_mux_arbiter2.sv
// tb/tb_mux_arbiter2.sv - directed self-checking bench for mux_arbiter2
module tb_mux_arbiter2;

  logic       clk;
  logic       reset_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel;
  logic       busy;
  logic       preempt;
  logic [1:0] req0;
  logic [1:0] gnt0;
  logic       sel0;
  logic       busy0;
  logic       preempt0;

  int checks;
  int errors;

  mux_arbiter2 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  mux_arbiter2 #(.MAX_HOLD(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req0),
    .gnt     (gnt0),
    .sel     (sel0),
    .busy    (busy0),
    .preempt (preempt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {gnt, sel, busy, preempt} of the MAX_HOLD=4 instance.
  task automatic chk(input string tag, input logic [1:0] eg, input logic es, input logic ep);
    logic [4:0] got;
    logic [4:0] exp;
    got = {gnt, sel, busy, preempt};
    exp = {eg, es, (eg != 2'b00), ep};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got gnt/sel/busy/pre=%b expected %b", tag, got, exp);
    end
  endtask

  // Compare {gnt, preempt} of the MAX_HOLD=0 instance.
  task automatic chk0(input string tag, input logic [1:0] eg, input logic ep);
    logic [2:0] got;
    logic [2:0] exp;
    got = {gnt0, preempt0};
    exp = {eg, ep};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got gnt/pre=%b expected %b", tag, got, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    req     = 2'b00;
    req0    = 2'b00;
    #2;
    chk("reset_state", 2'b00, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", 2'b00, 1'b0, 1'b0);

    // Single requester 1 for three cycles.
    req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_hold", 2'b10, 1'b1, 1'b0);
    end
    req = 2'b00;
    tick();
    chk("single_release_sel_holds", 2'b00, 1'b1, 1'b0);

    // Tie from IDLE with last=1, then requester 0 drops: direct handoff.
    req = 2'b11;
    tick();
    chk("tie_first", 2'b01, 1'b0, 1'b0);
    tick();
    chk("tie_second", 2'b01, 1'b0, 1'b0);
    req = 2'b10;
    tick();
    chk("handoff_no_gap", 2'b10, 1'b1, 1'b0);
    req = 2'b00;
    tick();
    chk("handoff_idle", 2'b00, 1'b1, 1'b0);

    // Fairness: one-cycle gaps between ties alternate the winner.
    req = 2'b11; tick(); chk("fair_a", 2'b01, 1'b0, 1'b0);
    req = 2'b00; tick(); chk("fair_gap_a", 2'b00, 1'b0, 1'b0);
    req = 2'b11; tick(); chk("fair_b", 2'b10, 1'b1, 1'b0);
    req = 2'b00; tick(); chk("fair_gap_b", 2'b00, 1'b1, 1'b0);
    req = 2'b11; tick(); chk("fair_c", 2'b01, 1'b0, 1'b0);
    req = 2'b00; tick(); chk("fair_gap_c", 2'b00, 1'b0, 1'b0);
    req = 2'b11; tick(); chk("fair_d", 2'b10, 1'b1, 1'b0);
    req = 2'b00; tick(); chk("fair_gap_d", 2'b00, 1'b1, 1'b0);

    // Continuous contention with MAX_HOLD=4.
    req = 2'b11;
    tick();
    chk("pre_own0_first", 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pre_own0_hold", 2'b01, 1'b0, 1'b0);
    end
    tick();
    chk("pre_switch_to1", 2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pre_own1_hold", 2'b10, 1'b1, 1'b0);
    end
    tick();
    chk("pre_switch_to0", 2'b01, 1'b0, 1'b1);
    req = 2'b00;
    tick();
    chk("pre_idle", 2'b00, 1'b0, 1'b0);

    // Interrupted wait: req[1] gap restarts the count.
    req = 2'b01;
    tick();
    chk("intr_own0", 2'b01, 1'b0, 1'b0);
    req = 2'b11;
    tick(); chk("intr_wait1", 2'b01, 1'b0, 1'b0);
    tick(); chk("intr_wait2", 2'b01, 1'b0, 1'b0);
    req = 2'b01;
    tick(); chk("intr_gap", 2'b01, 1'b0, 1'b0);
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("intr_rewait", 2'b01, 1'b0, 1'b0);
    end
    tick();
    chk("intr_switch", 2'b10, 1'b1, 1'b1);
    req = 2'b00;
    tick();
    chk("intr_idle", 2'b00, 1'b1, 1'b0);

    // Owner drops on the very edge preemption would fire: plain release.
    req = 2'b11;
    tick();
    chk("simul_own0", 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("simul_hold", 2'b01, 1'b0, 1'b0);
    end
    req = 2'b10;
    tick();
    chk("simul_release", 2'b10, 1'b1, 1'b0);
    req = 2'b00;
    tick();
    chk("simul_idle", 2'b00, 1'b1, 1'b0);

    // MAX_HOLD=0: owner is never preempted.
    req0 = 2'b11;
    tick();
    chk0("nohold_first", 2'b01, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk0("nohold_hold", 2'b01, 1'b0);
    end
    req0 = 2'b00;
    tick();
    chk0("nohold_idle", 2'b00, 1'b0);

    // Asynchronous reset while OWN1 with both requesting.
    req = 2'b10;
    tick();
    chk("rst_setup_own1", 2'b10, 1'b1, 1'b0);
    req = 2'b11;
    tick();
    chk("rst_setup_hold", 2'b10, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_immediate", 2'b00, 1'b0, 1'b0);
    tick();
    chk("rst_held", 2'b00, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("rst_first_grant", 2'b01, 1'b0, 1'b0);
    req = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
